// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_BOOT    = 2'd0,
      S_RUN     = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Instruction fetches are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. The head is read combinationally so a
// word pushed on one edge is visible immediately after that edge.
module fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [31:0]
) (
   input  logic                         clk,
   input  logic                         _reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  T                             din,
   output T                             head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   T                 mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_pop;
   logic             do_push;

   // A pop frees a slot in the same cycle, so push+pop is legal even when full.
   assign do_pop  = pop & (count_reg != '0);
   assign do_push = push & ((count_reg != FULL_CNT) | do_pop);

   // Storage has no reset; consumers gate the head with count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   // Pointer and occupancy update; flush behaves like reset.
   always_ff @(posedge clk) begin
      if (!_reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, pairs each
// returned word with its address, and flushes everything on a redirect.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        _reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4
);

   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int LIMIT_W = CNT_W + 1;
   localparam logic [LIMIT_W-1:0] DEPTH_LIMIT = LIMIT_W'(DEPTH);

   fetch_state_t     state_reg, state_next;
   logic [31:0]      fetch_pc_reg, fetch_pc_next;
   logic [CNT_W-1:0] outstanding_reg, outstanding_next;
   logic [CNT_W-1:0] discard_reg, discard_next;
   logic [CNT_W-1:0] entry_count;
   logic [CNT_W-1:0] addr_count;
   logic [31:0]      addr_head;
   fetch_entry_t     entry_head;
   fetch_entry_t     entry_din;
   logic [LIMIT_W-1:0] occupancy;
   logic             req_fire;
   logic             pop;
   logic             live_rsp;

   // Buffered words plus in-flight fetches bound how many more we may issue.
   assign occupancy      = {1'b0, entry_count} + {1'b0, outstanding_reg};
   assign imem_req_valid = (state_reg == S_RUN) && (occupancy < DEPTH_LIMIT) && !redirect_valid;
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign out_valid      = (entry_count != '0);
   assign pop            = out_valid & out_ready;
   // Only responses to the current fetch stream are kept.
   assign live_rsp       = imem_rsp_valid & (state_reg == S_RUN) & ~redirect_valid;
   assign entry_din      = '{pc: addr_head, instr: imem_rsp_data};

   assign out_instr = out_valid ? entry_head.instr : 32'd0;
   assign out_pc    = out_valid ? entry_head.pc : 32'd0;
   assign out_pc4   = out_valid ? (entry_head.pc + PC_STEP) : 32'd0;

   // Addresses of live in-flight fetches, oldest first.
   fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_addr_fifo (
      .clk    (clk),
      ._reset (_reset),
      .push   (req_fire),
      .pop    (live_rsp),
      .flush  (redirect_valid),
      .din    (fetch_pc_reg),
      .head   (addr_head),
      .count  (addr_count)
   );

   // Returned instructions waiting for the IF/ID register.
   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_entry_fifo (
      .clk    (clk),
      ._reset (_reset),
      .push   (live_rsp),
      .pop    (pop),
      .flush  (redirect_valid),
      .din    (entry_din),
      .head   (entry_head),
      .count  (entry_count)
   );

   // Next-state logic; redirect overrides whatever the current state wants.
   always_comb begin
      state_next       = state_reg;
      fetch_pc_next    = fetch_pc_reg;
      discard_next     = discard_reg;
      // outstanding counts every fetch still owed a response, stale or live
      outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
         fetch_pc_next = word_align(redirect_pc);
         discard_next  = outstanding_next;
         state_next    = (outstanding_next != '0) ? S_DISCARD : S_RUN;
      end else begin
         case (state_reg)
            S_BOOT: begin
               state_next = S_RUN;
            end
            S_RUN: begin
               if (req_fire) begin
                  fetch_pc_next = fetch_pc_reg + PC_STEP;
               end
            end
            S_DISCARD: begin
               if (imem_rsp_valid) begin
                  discard_next = discard_reg - CNT_W'(1);
                  if (discard_reg == CNT_W'(1)) begin
                     state_next = S_RUN;
                  end
               end
            end
            default: begin
               state_next = S_BOOT;
            end
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!_reset) begin
         state_reg       <= S_BOOT;
         fetch_pc_reg    <= RESET_PC;
         outstanding_reg <= '0;
         discard_reg     <= '0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
      end
   end

   // Memory must never answer a fetch that was not issued.
   a_rsp_has_owner: assert property (@(posedge clk) disable iff (!_reset)
      imem_rsp_valid |-> (outstanding_reg != '0));
   a_outstanding_bound: assert property (@(posedge clk) disable iff (!_reset)
      outstanding_reg <= CNT_W'(DEPTH));
   a_addr_tracking: assert property (@(posedge clk) disable iff (!_reset)
      (state_reg == S_RUN) |-> (addr_count == outstanding_reg));

endmodule
